reg_file_2r1w: RTL

- Parametrised 2-read/1-write register array. Successor to the fixed 32-bit, 8-entry register array.
- Adds synchronous writes, registered reads with write-to-read bypass, and a hardware clear sequencer that zeroes every entry on request.
- Sits in the CPU datapath between decode (register addresses) and execute/writeback (operands and results).

---
 rtl/reg_file_2r1w.sv | 122 ++++++++++++
 1 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised 2-read/1-write register array.
// Synchronous writes, registered reads with write-to-read bypass, and a
// clear sequencer that zeroes one entry per cycle.
// Optional build macro: REGFILE_R0_ZERO_EN -- entry 0 hardwired to zero.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | normal operation, writes accepted, clearStart honoured
// CLEAR | zeroing entry[clr_cnt] each cycle, writes and clearStart dropped

module reg_file_2r1w #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 writeEnable,
    input  logic [BITS_ADDR-1:0] dirrInput,
    input  logic [BITS_DATA-1:0] inputData,
    input  logic [BITS_ADDR-1:0] dirrOutput1,
    input  logic [BITS_ADDR-1:0] dirrOutput2,
    output logic [BITS_DATA-1:0] outputData1,
    output logic [BITS_DATA-1:0] outputData2,
    input  logic                 clearStart,
    output logic                 busy
);

    localparam int DEPTH = 2 ** BITS_ADDR;
    localparam logic [BITS_ADDR-1:0] LAST_ADDR = BITS_ADDR'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [BITS_ADDR-1:0] clr_cnt, clr_cnt_nxt;

    logic                 wr_en;
    logic                 wr_en_eff;
    logic [BITS_ADDR-1:0] wr_addr;
    logic [BITS_DATA-1:0] wr_data;

    logic [BITS_DATA-1:0] regs [DEPTH];

    // State and clear counter registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next state and write-port selection: clear sequencer owns the write
    // port while running; a clearStart in IDLE discards that cycle's write.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_en       = 1'b0;
        wr_addr     = dirrInput;
        wr_data     = inputData;
        case (state)
            IDLE: begin
                if (clearStart) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end else begin
                    wr_en = writeEnable;
                end
            end
            CLEAR: begin
                wr_en       = 1'b1;
                wr_addr     = clr_cnt;
                wr_data     = '0;
                clr_cnt_nxt = clr_cnt + BITS_ADDR'(1);
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

`ifdef REGFILE_R0_ZERO_EN
    // Entry 0 never takes a write, so it stays at its reset value of zero
    // and gating here also suppresses forwarding of writes to address 0.
    assign wr_en_eff = wr_en && (wr_addr != '0);
`else
    assign wr_en_eff = wr_en;
`endif

    assign busy = (state == CLEAR);

    // Register array: cleared on reset, one synchronous write per cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_eff) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Registered read ports with same-edge write forwarding.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outputData1 <= '0;
            outputData2 <= '0;
        end else begin
            outputData1 <= (wr_en_eff && (wr_addr == dirrOutput1)) ? wr_data : regs[dirrOutput1];
            outputData2 <= (wr_en_eff && (wr_addr == dirrOutput2)) ? wr_data : regs[dirrOutput2];
        end
    end

endmodule
